// File: rtl/mt9v034_capture.sv
// Captures the next complete MT9V034 frame after an arm request into a show-ahead pixel FIFO.
// Pixels are truncated to 8 bits and tagged with start-of-frame / end-of-line markers.

// Generic show-ahead FIFO: head entry is visible on rd_dat whenever rd_vld is high.
// Latency: a write is visible on rd_vld the cycle after it is accepted.
// Backpressure: wr_rdy low when full (caller drops); rd_dat holds while rd_vld & ~rd_rdy.
module mt9v034_fifo #(
  parameter int W     = 10,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_vld,
  input  logic [W-1:0] wr_dat,
  output logic         wr_rdy,
  output logic         rd_vld,
  output logic [W-1:0] rd_dat,
  input  logic         rd_rdy
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   cnt;
  logic          do_wr;
  logic          do_rd;

  // DEPTH is a power of two, so the count MSB alone marks full.
  assign wr_rdy = ~cnt[AW];
  assign rd_vld = (cnt != '0);
  assign rd_dat = mem[rptr];
  assign do_wr  = wr_vld & wr_rdy;
  assign do_rd  = rd_vld & rd_rdy;

  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr] <= wr_dat;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_wr) wptr <= wptr + 1'b1;
      if (do_rd) rptr <= rptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// Single-frame capture: input register, arm/frame FSM, one-pixel lookahead, pixel FIFO.
// Latency: bus sample to held pixel 2 cycles; held pixel written on next pixel or line end.
// Backpressure: m_valid/m_ready stream; pixels arriving on a full FIFO are dropped and flagged.
module mt9v034_capture #(
  parameter int FIFO_DEPTH = 16,
  parameter int COL_W      = 10,
  parameter int ROW_W      = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             arm,
  input  logic             pix_en,
  input  logic             frame_valid,
  input  logic             line_valid,
  input  logic [9:0]       pix_data,
  output logic [7:0]       m_data,
  output logic             m_sof,
  output logic             m_eol,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic [ROW_W-1:0] frame_lines,
  output logic [COL_W-1:0] line_pixels
);
  typedef enum logic [2:0] {IDLE, WAIT_FV_LOW, WAIT_FV_HIGH, CAPTURE, FLUSH} state_t;

  state_t           state;
  logic             en_r;
  logic             fv_r;
  logic             lv_r;
  logic [7:0]       dat_r;
  logic             fv_p;
  logic             lv_p;
  logic             fv_rise;
  logic             fv_fall;
  logic             pix_take;
  logic             line_end;
  logic             sof_pend;
  logic             hold_vld;
  logic             hold_sof;
  logic [7:0]       hold_dat;
  logic [COL_W-1:0] col_cnt;
  logic [ROW_W-1:0] row_cnt;
  logic             wr_vld;
  logic             wr_eol;
  logic             wr_rdy;
  logic [9:0]       wr_dat;
  logic             rd_vld;
  logic [9:0]       rd_dat;
  logic             unused_lsb;

  assign unused_lsb = ^pix_data[1:0];

  // Previous-sample copies advance only on strobed cycles so edges are in PIXCLK terms.
  always_ff @(posedge clk) begin
    if (!reset) begin
      en_r  <= 1'b0;
      fv_r  <= 1'b0;
      lv_r  <= 1'b0;
      dat_r <= '0;
      fv_p  <= 1'b0;
      lv_p  <= 1'b0;
    end else begin
      en_r  <= pix_en;
      fv_r  <= frame_valid;
      lv_r  <= line_valid;
      dat_r <= pix_data[9:2];
      if (en_r) begin
        fv_p <= fv_r;
        lv_p <= lv_r;
      end
    end
  end

  assign fv_rise  = en_r & fv_r & ~fv_p;
  assign fv_fall  = en_r & ~fv_r & fv_p;
  assign pix_take = (state == CAPTURE) & en_r & fv_r & lv_r;
  // A frame ending mid-line closes that line as well.
  assign line_end = (state == CAPTURE) & en_r & lv_p & ~(fv_r & lv_r);

  always_comb begin
    wr_vld = 1'b0;
    wr_eol = 1'b0;
    if (hold_vld) begin
      if (state == FLUSH || line_end) begin
        wr_vld = 1'b1;
        wr_eol = 1'b1;
      end else if (pix_take) begin
        wr_vld = 1'b1;
      end
    end
  end

  assign wr_dat = {hold_sof, wr_eol, hold_dat};

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      overflow    <= 1'b0;
      sof_pend    <= 1'b0;
      hold_vld    <= 1'b0;
      hold_sof    <= 1'b0;
      hold_dat    <= '0;
      col_cnt     <= '0;
      row_cnt     <= '0;
      frame_lines <= '0;
      line_pixels <= '0;
    end else begin
      done <= 1'b0;
      if (wr_vld && !wr_rdy) overflow <= 1'b1;
      case (state)
        IDLE: begin
          if (arm) begin
            state    <= WAIT_FV_LOW;
            busy     <= 1'b1;
            overflow <= 1'b0;
            sof_pend <= 1'b0;
            col_cnt  <= '0;
            row_cnt  <= '0;
          end
        end
        WAIT_FV_LOW: begin
          if (en_r && !fv_r) state <= WAIT_FV_HIGH;
        end
        WAIT_FV_HIGH: begin
          if (fv_rise) begin
            state    <= CAPTURE;
            sof_pend <= 1'b1;
          end
        end
        CAPTURE: begin
          if (pix_take) begin
            hold_vld <= 1'b1;
            hold_dat <= dat_r;
            hold_sof <= sof_pend;
            sof_pend <= 1'b0;
            if (!lv_p)              col_cnt <= COL_W'(1);
            else if (col_cnt != '1) col_cnt <= col_cnt + 1'b1;
          end else if (line_end) begin
            hold_vld <= 1'b0;
            if (row_cnt != '1) row_cnt <= row_cnt + 1'b1;
          end
          if (fv_fall) state <= FLUSH;
        end
        FLUSH: begin
          hold_vld    <= 1'b0;
          done        <= 1'b1;
          busy        <= 1'b0;
          frame_lines <= row_cnt;
          line_pixels <= col_cnt;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  mt9v034_fifo #(.W(10), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .wr_vld (wr_vld),
    .wr_dat (wr_dat),
    .wr_rdy (wr_rdy),
    .rd_vld (rd_vld),
    .rd_dat (rd_dat),
    .rd_rdy (m_ready)
  );

  assign m_valid = rd_vld;
  assign m_data  = rd_vld ? rd_dat[7:0] : 8'h00;
  assign m_eol   = rd_vld & rd_dat[8];
  assign m_sof   = rd_vld & rd_dat[9];
endmodule

// File: tb/tb_mt9v034_capture.sv
// Scoreboard bench for mt9v034_capture: stimulus queues expected {sof,eol,data}, a monitor pops on transfer.
module tb_mt9v034_capture;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       arm = 1'b0;
  logic       pix_en = 1'b1;
  logic       frame_valid = 1'b0;
  logic       line_valid = 1'b0;
  logic [9:0] pix_data = '0;
  logic       m_ready = 1'b1;
  logic [7:0] m_data;
  logic       m_sof;
  logic       m_eol;
  logic       m_valid;
  logic       busy;
  logic       done;
  logic       overflow;
  logic [8:0] frame_lines;
  logic [9:0] line_pixels;

  int         checks = 0;
  int         failures = 0;
  int         done_cnt = 0;
  logic [9:0] exp_q[$];
  bit         slow = 1'b0;
  bit         toggle_rdy = 1'b0;
  bit         stalled = 1'b0;
  logic [9:0] stall_dat = '0;

  mt9v034_capture #(.FIFO_DEPTH(16), .COL_W(10), .ROW_W(9)) dut (
    .clk(clk), .reset(reset), .arm(arm), .pix_en(pix_en),
    .frame_valid(frame_valid), .line_valid(line_valid), .pix_data(pix_data),
    .m_data(m_data), .m_sof(m_sof), .m_eol(m_eol), .m_valid(m_valid), .m_ready(m_ready),
    .busy(busy), .done(done), .overflow(overflow),
    .frame_lines(frame_lines), .line_pixels(line_pixels)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (reset) begin
      if (stalled) begin
        check("stall_valid", int'(m_valid), 1);
        check("stall_data", int'({m_sof, m_eol, m_data}), int'(stall_dat));
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output actual=%h required=none", {m_sof, m_eol, m_data});
        end else begin
          check("pixel", int'({m_sof, m_eol, m_data}), int'(exp_q.pop_front()));
        end
      end
      stalled   = m_valid & ~m_ready;
      stall_dat = {m_sof, m_eol, m_data};
      if (done) done_cnt++;
    end else begin
      stalled = 1'b0;
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (toggle_rdy) m_ready = ~m_ready;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One bus sample; in slow mode it is preceded by a non-strobed cycle carrying junk.
  task automatic bus(input logic fv, input logic lv, input logic [9:0] d);
    if (slow) begin
      pix_en = 1'b0; frame_valid = ~fv; line_valid = ~lv; pix_data = 10'h3FF;
      tick();
    end
    pix_en = 1'b1; frame_valid = fv; line_valid = lv; pix_data = d;
    tick();
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
    check("busy_after_arm", int'(busy), 1);
    check("overflow_cleared_on_arm", int'(overflow), 0);
  endtask

  // Pixel n carries data 4*n; trunc>0 cuts the last line after trunc pixels with FV falling.
  task automatic frame(input int lines, input int pix, input int trunc, input bit expect_out, input int max_exp);
    int n = 0;
    bus(1'b1, 1'b0, '0);
    bus(1'b1, 1'b0, '0);
    for (int l = 0; l < lines; l++) begin
      int np = (trunc > 0 && l == lines - 1) ? trunc : pix;
      for (int p = 0; p < np; p++) begin
        if (expect_out && n < max_exp) exp_q.push_back({n == 0, p == np - 1, n[7:0]});
        bus(1'b1, 1'b1, 10'(4 * n));
        n++;
      end
      if (!(trunc > 0 && l == lines - 1)) begin
        for (int g = 0; g < 3; g++) bus(1'b1, 1'b0, '0);
      end
    end
    for (int i = 0; i < 4; i++) bus(1'b0, 1'b0, '0);
  endtask

  task automatic drain(input string name);
    int t = 0;
    while ((exp_q.size() != 0 || m_valid) && t < 500) begin
      tick();
      t++;
    end
    check({name, "_queue_empty"}, exp_q.size(), 0);
    check({name, "_valid_low"}, int'(m_valid), 0);
  endtask

  task automatic frame_result(input string name, input int d0, input int lines, input int pix);
    check({name, "_done_pulses"}, done_cnt - d0, 1);
    check({name, "_frame_lines"}, int'(frame_lines), lines);
    check({name, "_line_pixels"}, int'(line_pixels), pix);
    check({name, "_busy_low"}, int'(busy), 0);
  endtask

  initial begin
    int d0;
    repeat (3) tick();
    check("rst_m_valid", int'(m_valid), 0);
    check("rst_m_sof", int'(m_sof), 0);
    check("rst_m_eol", int'(m_eol), 0);
    check("rst_m_data", int'(m_data), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_frame_lines", int'(frame_lines), 0);
    check("rst_line_pixels", int'(line_pixels), 0);
    reset = 1'b1;
    repeat (3) tick();

    // Basic 4x8 frame, m_ready high.
    d0 = done_cnt;
    do_arm();
    frame(4, 8, 0, 1'b1, 1000);
    drain("basic");
    frame_result("basic", d0, 4, 8);
    check("basic_overflow", int'(overflow), 0);

    // Arm while a frame is already in progress: that frame must be skipped.
    bus(1'b1, 1'b0, '0);
    for (int i = 0; i < 3; i++) bus(1'b1, 1'b1, 10'h200);
    d0 = done_cnt;
    do_arm();
    for (int i = 0; i < 3; i++) bus(1'b1, 1'b1, 10'h204);
    bus(1'b1, 1'b0, '0);
    for (int i = 0; i < 4; i++) bus(1'b0, 1'b0, '0);
    check("midarm_still_busy", int'(busy), 1);
    frame(2, 8, 0, 1'b1, 1000);
    drain("midarm");
    frame_result("midarm", d0, 2, 8);

    // Stalled sink over a 3x8 frame: first 16 pixels retained.
    m_ready = 1'b0;
    d0 = done_cnt;
    do_arm();
    frame(3, 8, 0, 1'b1, 16);
    repeat (3) tick();
    check("ovf_flag", int'(overflow), 1);
    check("ovf_valid_held", int'(m_valid), 1);
    frame_result("ovf", d0, 3, 8);
    m_ready = 1'b1;
    drain("ovf");

    // Toggling m_ready with a half-rate pixel strobe.
    toggle_rdy = 1'b1;
    slow = 1'b1;
    d0 = done_cnt;
    do_arm();
    frame(3, 8, 0, 1'b1, 1000);
    drain("bp");
    toggle_rdy = 1'b0;
    slow = 1'b0;
    tick();
    m_ready = 1'b1;
    frame_result("bp", d0, 3, 8);
    check("bp_overflow", int'(overflow), 0);

    // Frame ends mid-line after 5 pixels of line 2.
    d0 = done_cnt;
    do_arm();
    frame(2, 8, 5, 1'b1, 1000);
    drain("trunc");
    frame_result("trunc", d0, 2, 5);

    // Reset in the middle of a capture.
    m_ready = 1'b0;
    d0 = done_cnt;
    do_arm();
    bus(1'b1, 1'b0, '0);
    bus(1'b1, 1'b0, '0);
    for (int i = 0; i < 8; i++) bus(1'b1, 1'b1, 10'(4 * i));
    for (int i = 0; i < 3; i++) bus(1'b1, 1'b0, '0);
    for (int i = 0; i < 4; i++) bus(1'b1, 1'b1, 10'h100);
    check("prerst_valid", int'(m_valid), 1);
    reset = 1'b0;
    bus(1'b1, 1'b1, 10'h104);
    check("midrst_busy", int'(busy), 0);
    check("midrst_valid", int'(m_valid), 0);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) bus(1'b1, 1'b1, 10'h108);
    bus(1'b1, 1'b0, '0);
    for (int i = 0; i < 4; i++) bus(1'b0, 1'b0, '0);
    check("postrst_valid", int'(m_valid), 0);
    check("postrst_busy", int'(busy), 0);
    check("postrst_no_done", done_cnt - d0, 0);
    m_ready = 1'b1;
    d0 = done_cnt;
    do_arm();
    frame(2, 4, 0, 1'b1, 1000);
    drain("rearm");
    frame_result("rearm", d0, 2, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mt9v034_capture.md
# mt9v034_capture

Single-frame pixel capture stage downstream of the MT9V034 camera controller. On an `arm` request it waits for the next complete frame on the sensor parallel bus (FRAME_VALID / LINE_VALID / DOUT). It truncates each 10-bit pixel to 8 bits, tags start-of-frame and end-of-line, and buffers the pixels in a small FIFO. A valid/ready stream drains the FIFO toward the UART/storage path. It runs entirely in the 24 MHz camera clock domain that drives the sensor SYSCLK.

## Interface
- `FIFO_DEPTH`, 16, FIFO entries; power of two, ≥4
- `COL_W`, 10, pixel-per-line counter width
- `ROW_W`, 9, line-per-frame counter width
- `clk`  in  1  24 MHz camera clock; all logic on rising edge
- `reset`  in  1  synchronous, active-low reset
- `arm`  in  1  one-cycle request to capture the next full frame (typically the debounced trigger, edge-detected upstream)
- `pix_en`  in  1  sample strobe: bus inputs are valid this cycle (tie high when PIXCLK == clk)
- `frame_valid`  in  1  sensor FRAME_VALID
- `line_valid`  in  1  sensor LINE_VALID
- `pix_data`  in  10  sensor DOUT[9:0]
- `m_data`  out  8  pixel = `pix_data[9:2]`
- `m_sof`  out  1  qualifies `m_data`: first pixel of frame
- `m_eol`  out  1  qualifies `m_data`: last pixel of a line
- `m_valid`  out  1  stream valid
- `m_ready`  in  1  stream ready
- `busy`  out  1  capture in progress (state ≠ IDLE)
- `done`  out  1  one-cycle pulse, frame fully written to FIFO
- `overflow`  out  1  sticky: ≥1 pixel dropped on full FIFO; cleared on accepted `arm`
- `frame_lines`  out  ROW_W  lines in last captured frame
- `line_pixels`  out  COL_W  pixels in last line of last frame

## Operation
- Input register stage: `frame_valid`, `line_valid`, `pix_data` and `pix_en` are registered once. All edge detection uses the registered copies and their previous values, updated only on `pix_en` cycles.
- FSM states:
  - IDLE: on `arm` → WAIT_FV_LOW. Clear `overflow` and the counters.
  - WAIT_FV_LOW: FV low sampled → WAIT_FV_HIGH. This skips a frame already in progress.
  - WAIT_FV_HIGH: FV rising edge → CAPTURE. Set the pending-SOF flag.
  - CAPTURE: on each `pix_en` with FV & LV high, take a pixel. FV falling edge → FLUSH.
  - FLUSH: write any held pixel (with `m_eol`=1), pulse `done`, latch the counts → IDLE.
- `arm` outside IDLE is ignored.
- One-pixel lookahead holding register, so `m_eol` is known at write time:
  - A new pixel pushes the held pixel to the FIFO with eol=0.
  - An LV falling edge pushes the held pixel with eol=1.
  - The first pixel after FV rise carries sof=1.
- Counters:
  - Column counter increments per pixel and resets on LV rise.
  - Row counter increments on each LV falling edge inside CAPTURE.
  - Both saturate at all-ones, no wrap.
  - `line_pixels` and `frame_lines` update only in FLUSH and hold until the next FLUSH.
- FIFO: 10 bits wide ({sof, eol, data}), show-ahead.
  - A write is accepted iff the FIFO is not full at that cycle; simultaneous read and write when not full both occur.
  - A write to a full FIFO drops the pixel and sets `overflow`. sof/eol markers in a dropped entry are lost.
- Stream: transfer when `m_valid & m_ready`. `m_data`, `m_sof` and `m_eol` stay stable while `m_valid & ~m_ready`.
- An FV fall during LV high (truncated line) is treated as an LV fall: eol=1, row counted.
- Reset mid-capture: FSM → IDLE, FIFO emptied, held pixel discarded.

## Timing
- Reset values:
  - `m_valid`, `m_sof`, `m_eol`, `busy`, `done`, `overflow` = 0
  - `m_data`, `frame_lines`, `line_pixels` = 0
  - FIFO empty
- Pixel latency: bus sample → held register takes 2 cycles (input reg + hold). The held pixel is written on the next pixel or LV fall. `m_valid` rises the cycle after the write into an empty FIFO.
- `busy` rises the cycle after `arm` is accepted and falls in the same cycle `done` pulses.
- `done` is high exactly one cycle, in FLUSH.
- Sustained throughput: 1 pixel/cycle with `m_ready` held high.

## Test plan
- Arm with FV low, then a 4-line × 8-pixel frame (data = 4·n) and `m_ready`=1 → 32 outputs; m_data = n[7:0]; sof only on the first; eol on pixels 7/15/23/31; `done` pulses once; frame_lines=4, line_pixels=8.
- Arm mid-frame (FV already high) → that frame is ignored; the next full frame is captured with exactly one sof.
- `m_ready`=0 for a whole 3×8 frame with FIFO_DEPTH=16 → 16 entries retained, `overflow`=1. Releasing `m_ready` yields 16 pixels, unchanged and in order.
- Backpressure toggling `m_ready` every other cycle → no loss, and outputs stay stable while stalled.
- FV falls while LV is high after 5 pixels of line 2 → last pixel has eol=1, frame_lines=2, line_pixels=5.
- `reset` low mid-CAPTURE → next cycle: busy=0, m_valid=0, FIFO empty. A subsequent arm captures normally.
